reg_file_wb: RTL and testbench

- Architectural register file and write-back endpoint of the single-cycle MIPS datapath: 32 x 32-bit registers, two read ports, one write port.
- Consumes the write-register index (RegDst select: rt/rd/$ra) and write-back data (ALU/memory/PC+4/upper-immediate select). Decodes the index one-hot and commits the data on the clock edge.
- ReadData1 feeds the ALU A input. ReadData2 feeds the ALUsrc select and the data-memory store path.

---
 rtl/reg_file_wb_if.sv | 23 ++
 rtl/reg_file_wb.sv | 104 ++++++++++
 tb/tb_reg_file_wb.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_wb_if.sv
// Register-file bus: write-back port, two read ports and write trace outputs.
// The datapath side drives the master modport; the register file is the slave.
interface reg_file_wb_if;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteOneHot;
  logic [31:0] WriteCount;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, WriteOneHot, WriteCount
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, WriteOneHot, WriteCount
  );
endinterface

// File: rtl/reg_file_wb.sv
// MIPS architectural register file with one-hot write decode, optional
// read-during-write forwarding, and a registered write trace and write counter.
module reg_file_wb #(
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  reg_file_wb_if.slave bus
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] dec_s;
  logic [31:0] onehot_q;
  logic [31:0] onehot_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;

  function automatic logic [31:0] reset_value(input logic [4:0] idx);
    logic [31:0] v;
    case (idx)
      5'd28:   v = GP_INIT;
      5'd29:   v = SP_INIT;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // $zero always reads zero, even when a forward would otherwise apply
  function automatic logic [31:0] read_mux(input logic [4:0]  idx,
                                           input logic [31:0] stored,
                                           input logic        fwd,
                                           input logic [31:0] wdata);
    logic [31:0] v;
    if (idx == 5'd0) begin
      v = 32'h0000_0000;
    end else if (fwd) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // One-hot write decode; bit 0 stays low so $zero is never written
  always_comb begin
    dec_s = 32'h0000_0000;
    for (int i = 1; i < 32; i++) begin
      dec_s[i] = bus.RegWrite & (bus.WriteRegister == 5'(i));
    end
  end

  // Next-state for storage, write trace and write counter
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      if (dec_s[i]) begin
        regs_d[i] = bus.WriteData;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    onehot_d = dec_s;
    if (|dec_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State register; reset wins over any write set up in the same cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= reset_value(5'(i));
      end
      onehot_q <= 32'h0000_0000;
      count_q  <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      onehot_q <= onehot_d;
      count_q  <= count_d;
    end
  end

  // Read ports; forwarding is suppressed while reset holds the array
  always_comb begin
    rd1_s = read_mux(bus.ReadRegister1, regs_q[bus.ReadRegister1],
                     BYPASS && !reset && dec_s[bus.ReadRegister1], bus.WriteData);
    rd2_s = read_mux(bus.ReadRegister2, regs_q[bus.ReadRegister2],
                     BYPASS && !reset && dec_s[bus.ReadRegister2], bus.WriteData);
  end

  assign bus.ReadData1   = rd1_s;
  assign bus.ReadData2   = rd2_s;
  assign bus.WriteOneHot = onehot_q;
  assign bus.WriteCount  = count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: a forwarding and a non-forwarding instance share stimulus;
// directed table, reset corner sequence and random traffic against an array model.
module tb_reg_file_wb;

  localparam logic [31:0] SP_V = 32'h0000_3FFC;
  localparam logic [31:0] GP_V = 32'h0000_1800;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  reg_file_wb_if if_b ();
  reg_file_wb_if if_n ();

  reg_file_wb #(.SP_INIT(SP_V), .GP_INIT(GP_V), .BYPASS(1'b1)) dut_b (
    .clock(clock), .reset(reset), .bus(if_b)
  );
  reg_file_wb #(.SP_INIT(SP_V), .GP_INIT(GP_V), .BYPASS(1'b0)) dut_n (
    .clock(clock), .reset(reset), .bus(if_n)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_onehot;
  logic [31:0] m_count;
  logic        cur_rw;
  logic [4:0]  cur_wr;
  logic [31:0] cur_wd;
  logic [4:0]  cur_r1;
  logic [4:0]  cur_r2;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] pre_b;
    logic [31:0] pre_n;
    logic [31:0] post1;
    logic [31:0] post2;
    logic [31:0] onehot;
    logic [31:0] count;
  } row_t;

  row_t rows [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
    cur_rw = rw; cur_wr = wr; cur_wd = wd; cur_r1 = r1; cur_r2 = r2;
    if_b.RegWrite = rw; if_b.WriteRegister = wr; if_b.WriteData = wd;
    if_b.ReadRegister1 = r1; if_b.ReadRegister2 = r2;
    if_n.RegWrite = rw; if_n.WriteRegister = wr; if_n.WriteData = wd;
    if_n.ReadRegister1 = r1; if_n.ReadRegister2 = r2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_regs[28] = GP_V;
    m_regs[29] = SP_V;
    m_onehot = 32'h0;
    m_count  = 32'h0;
  endtask

  task automatic model_edge();
    if (cur_rw && cur_wr != 5'd0) begin
      m_regs[cur_wr] = cur_wd;
      m_onehot = 32'h1 << cur_wr;
      m_count  = m_count + 32'd1;
    end else begin
      m_onehot = 32'h0;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'h0;
    if (byp && cur_rw && idx == cur_wr) return cur_wd;
    return m_regs[idx];
  endfunction

  initial begin
    //            rw    wr     wd            rr1    rr2    pre_b         pre_n         post1         post2         onehot        count
    rows[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd28, 32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, GP_V,         32'h0000_0020, 32'd1};
    rows[1] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0,         32'h0,        32'h0,         32'h0,        32'h0,         32'd1};
    rows[2] = '{1'b1, 5'd8,  32'h0000_0001, 5'd8,  5'd5,  32'h1,         32'h0,        32'h1,         32'hDEAD_BEEF, 32'h0000_0100, 32'd2};
    rows[3] = '{1'b1, 5'd8,  32'h0000_0002, 5'd8,  5'd8,  32'h2,         32'h1,        32'h2,         32'h2,        32'h0000_0100, 32'd3};
    rows[4] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd29, 32'h0,         32'h0,        32'h0,         SP_V,         32'h0,         32'd3};
    rows[5] = '{1'b1, 5'd31, 32'hCAFE_0001, 5'd31, 5'd0,  32'hCAFE_0001, 32'h0,        32'hCAFE_0001, 32'h0,        32'h8000_0000, 32'd4};
    rows[6] = '{1'b1, 5'd29, 32'hA5A5_A5A5, 5'd29, 5'd28, 32'hA5A5_A5A5, SP_V,         32'hA5A5_A5A5, GP_V,         32'h2000_0000, 32'd5};
    rows[7] = '{1'b1, 5'd1,  32'h0000_0011, 5'd1,  5'd1,  32'h11,        32'h0,        32'h11,        32'h11,       32'h0000_0002, 32'd6};

    set_in(1'b0, 5'd0, 32'h0, 5'd28, 5'd29);
    // Asynchronous reset pulse before the first clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_r28", if_b.ReadData1, GP_V);
    check("rst_r29", if_b.ReadData2, SP_V);
    check("rst_cnt", if_b.WriteCount, 32'h0);
    check("rst_oh", if_b.WriteOneHot, 32'h0);
    set_in(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    check("rst_r1", if_b.ReadData1, 32'h0);
    check("rst_r31", if_n.ReadData2, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(posedge clock); #1;

    foreach (rows[r]) begin
      set_in(rows[r].rw, rows[r].wr, rows[r].wd, rows[r].rr1, rows[r].rr2);
      #1;
      check($sformatf("row%0d_pre_byp", r), if_b.ReadData1, rows[r].pre_b);
      check($sformatf("row%0d_pre_nobyp", r), if_n.ReadData1, rows[r].pre_n);
      model_edge();
      @(posedge clock); #1;
      set_in(1'b0, rows[r].wr, rows[r].wd, rows[r].rr1, rows[r].rr2);
      #1;
      check($sformatf("row%0d_rd1", r), if_b.ReadData1, rows[r].post1);
      check($sformatf("row%0d_rd2", r), if_n.ReadData2, rows[r].post2);
      check($sformatf("row%0d_onehot", r), if_b.WriteOneHot, rows[r].onehot);
      check($sformatf("row%0d_count", r), if_n.WriteCount, rows[r].count);
    end

    // Reset asserted after a write is set up: reset wins, edge commits nothing
    set_in(1'b1, 5'd29, 32'h5A5A_5A5A, 5'd29, 5'd8);
    #1;
    check("mid_pre_byp", if_b.ReadData1, 32'h5A5A_5A5A);
    reset = 1'b1;
    #1;
    check("mid_r29_byp", if_b.ReadData1, SP_V);
    check("mid_r29_nobyp", if_n.ReadData1, SP_V);
    check("mid_r8", if_b.ReadData2, 32'h0);
    @(posedge clock); #1;
    check("mid_edge_r29", if_b.ReadData1, SP_V);
    check("mid_edge_cnt", if_b.WriteCount, 32'h0);
    check("mid_edge_oh", if_n.WriteOneHot, 32'h0);
    set_in(1'b0, 5'd29, 32'h5A5A_5A5A, 5'd29, 5'd8);
    reset = 1'b0;
    model_reset();
    #1;
    set_in(1'b1, 5'd3, 32'h0000_0077, 5'd3, 5'd3);
    model_edge();
    @(posedge clock); #1;
    set_in(1'b0, 5'd3, 32'h0000_0077, 5'd3, 5'd29);
    #1;
    check("post_rst_wr", if_n.ReadData1, 32'h0000_0077);
    check("post_rst_r29", if_b.ReadData2, SP_V);
    check("post_rst_cnt", if_b.WriteCount, 32'd1);
    check("post_rst_oh", if_b.WriteOneHot, 32'h0000_0008);

    // Random traffic against the array model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      logic [4:0] r2;
      wr = 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 3) != 0), wr, $urandom, 5'($urandom_range(0, 31)), r2);
      if ($urandom_range(0, 3) == 0) begin
        set_in(cur_rw, cur_wr, cur_wd, cur_wr, cur_r2);
      end
      #1;
      check("rnd_rd1_byp", if_b.ReadData1, exp_read(cur_r1, 1'b1));
      check("rnd_rd2_byp", if_b.ReadData2, exp_read(cur_r2, 1'b1));
      check("rnd_rd1_nobyp", if_n.ReadData1, exp_read(cur_r1, 1'b0));
      check("rnd_rd2_nobyp", if_n.ReadData2, exp_read(cur_r2, 1'b0));
      model_edge();
      @(posedge clock); #1;
      check("rnd_onehot", if_b.WriteOneHot, m_onehot);
      check("rnd_count", if_n.WriteCount, m_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
